jt12_kon_multi: RTL and testbench

- Parametrised key-on tracker for the FM operator pipeline. Supports 3-channel (YM2203-class) and 6-channel (YM2612-class) builds.
- Holds one key bit per operator slot in a circular shift register. Emits the registered key state of the slot currently in the pipeline, plus one-cycle key-on and key-off edge flags.
- Adds a CSM window for channel 2: Timer A overflow keys all four operators for exactly one pass.
- Sits between the register interface (keyon writes) and the envelope generator (key state and edges).

---
 rtl/jt12_kon_multi_if.sv | 19 +
 rtl/jt12_kon_multi.sv | 132 +++++++++++++
 tb/tb_jt12_kon_multi.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_kon_multi_if.sv
// Key-on register bus: the 0x28 write (operator bits, channel code) and its
// pending flag, as driven by the register interface into the key-on tracker.
interface jt12_kon_multi_if;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;

  modport master (
    output keyon_op,
    output keyon_ch,
    output up_keyon
  );

  modport slave (
    input keyon_op,
    input keyon_ch,
    input up_keyon
  );
endinterface

// File: rtl/jt12_kon_multi.sv
// Key-on tracker for the FM operator pipeline: one key bit per slot kept in a
// circular ring, plus a one-pass CSM window on channel 2 driven by Timer A.
module jt12_kon_multi #(
  parameter int NUM_CH = 6,
  parameter int CSM_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  jt12_kon_multi_if.slave        kon_bus,
  input  logic [2:0]             cur_ch,
  input  logic [1:0]             cur_op,
  input  logic                   csm,
  input  logic                   overflow_A,
  output logic                   keyon_II,
  output logic                   keyon_now,
  output logic                   keyoff_now
);

  localparam int         RING_W   = NUM_CH * 4;
  localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);
  localparam logic       CSM_ON   = (CSM_EN != 0);

  // Register 0x28 channel code: 0..2 -> ch0..2, 4..6 -> ch3..5.
  function automatic logic [2:0] decode_ch(input logic [2:0] code);
    logic [2:0] idx;
    if (code[2]) begin
      idx = {1'b0, code[1:0]} + 3'd3;
    end else begin
      idx = {1'b0, code[1:0]};
    end
    return idx;
  endfunction

  // Pipeline operator phase order is S1,S3,S2,S4 while 0x28 bits are {S4,S3,S2,S1}.
  function automatic logic [3:0] op_sel(input logic [1:0] op);
    logic [3:0] sel;
    case (op)
      2'd0:    sel = 4'b0001;
      2'd1:    sel = 4'b0100;
      2'd2:    sel = 4'b0010;
      2'd3:    sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  logic [RING_W-1:0] key_ring_q, key_ring_d;
  logic [RING_W-1:0] eff_ring_q, eff_ring_d;
  logic              csm_pend_q, csm_pend_d;
  logic              csm_win_q,  csm_win_d;
  logic              keyon_II_q, keyon_II_d;
  logic              keyon_now_q, keyon_now_d;
  logic              keyoff_now_q, keyoff_now_d;

  logic [2:0] ch_idx_s;
  logic [3:0] sel_s;
  logic       wr_valid_s;
  logic       wr_hit_s;
  logic       drop_s;
  logic       prev_s;
  logic       din_s;
  logic       slot_ch2_s;
  logic       pend_eff_s;
  logic       win_set_s;
  logic       win_next_s;
  logic       csm_force_s;
  logic       eff_s;

  // Next-state for key ring, CSM window and registered edge outputs.
  always_comb begin
    ch_idx_s    = decode_ch(kon_bus.keyon_ch);
    sel_s       = op_sel(cur_op);
    wr_valid_s  = (kon_bus.keyon_ch[1:0] != 2'd3) && ({1'b0, ch_idx_s} < NUM_CH_W);
    wr_hit_s    = kon_bus.up_keyon && wr_valid_s && (ch_idx_s == cur_ch);
    drop_s      = key_ring_q[RING_W-1];
    prev_s      = eff_ring_q[RING_W-1];
    din_s       = wr_hit_s ? |(kon_bus.keyon_op & sel_s) : drop_s;

    // An overflow landing on the ch2/op0 slot opens the window in the same pass.
    slot_ch2_s  = (cur_ch == 3'd2);
    pend_eff_s  = CSM_ON && csm && (csm_pend_q || overflow_A);
    win_set_s   = pend_eff_s && slot_ch2_s && (cur_op == 2'd0);
    win_next_s  = csm_win_q || win_set_s;
    csm_force_s = win_next_s && slot_ch2_s;
    eff_s       = drop_s || csm_force_s;

    if (clk_en) begin
      key_ring_d   = {key_ring_q[RING_W-2:0], din_s};
      eff_ring_d   = {eff_ring_q[RING_W-2:0], eff_s};
      csm_pend_d   = pend_eff_s && !win_set_s;
      csm_win_d    = win_next_s && !(slot_ch2_s && (cur_op == 2'd3));
      keyon_II_d   = eff_s;
      keyon_now_d  = eff_s && !prev_s;
      keyoff_now_d = !eff_s && prev_s;
    end else begin
      key_ring_d   = key_ring_q;
      eff_ring_d   = eff_ring_q;
      csm_pend_d   = csm_pend_q;
      csm_win_d    = csm_win_q;
      keyon_II_d   = keyon_II_q;
      keyon_now_d  = keyon_now_q;
      keyoff_now_d = keyoff_now_q;
    end
  end

  // State registers; reset drops every stored key immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_ring_q   <= '0;
      eff_ring_q   <= '0;
      csm_pend_q   <= 1'b0;
      csm_win_q    <= 1'b0;
      keyon_II_q   <= 1'b0;
      keyon_now_q  <= 1'b0;
      keyoff_now_q <= 1'b0;
    end else begin
      key_ring_q   <= key_ring_d;
      eff_ring_q   <= eff_ring_d;
      csm_pend_q   <= csm_pend_d;
      csm_win_q    <= csm_win_d;
      keyon_II_q   <= keyon_II_d;
      keyon_now_q  <= keyon_now_d;
      keyoff_now_q <= keyoff_now_d;
    end
  end

  assign keyon_II   = keyon_II_q;
  assign keyon_now  = keyon_now_q;
  assign keyoff_now = keyoff_now_q;

endmodule

// File: tb/tb_jt12_kon_multi.sv
// Bench for jt12_kon_multi: a 6-channel and a 3-channel build share one key-on
// bus and are compared every clock against a per-slot behavioural model.
module tb_jt12_kon_multi;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic csm;
  logic ovf;
  logic [2:0] cur_ch6, cur_ch3;
  logic [1:0] cur_op6, cur_op3;
  logic ii6, on6, off6, ii3, on3, off3;

  jt12_kon_multi_if bus ();

  jt12_kon_multi #(.NUM_CH(6), .CSM_EN(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kon_bus(bus),
    .cur_ch(cur_ch6), .cur_op(cur_op6), .csm(csm), .overflow_A(ovf),
    .keyon_II(ii6), .keyon_now(on6), .keyoff_now(off6)
  );

  jt12_kon_multi #(.NUM_CH(3), .CSM_EN(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .kon_bus(bus),
    .cur_ch(cur_ch3), .cur_op(cur_op3), .csm(csm), .overflow_A(ovf),
    .keyon_II(ii3), .keyon_now(on3), .keyoff_now(off3)
  );

  always #5 clk = ~clk;

  // Model state, index 0 = 6-channel build, 1 = 3-channel build.
  bit       stored [2][24];
  bit       last   [2][24];
  bit       pend   [2];
  bit       win    [2];
  logic [2:0] exp_out [2];
  int       slot   [2];
  int       checks = 0;
  int       errors = 0;

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 24; s++) begin
        stored[m][s] = 1'b0;
        last[m][s]   = 1'b0;
      end
      pend[m] = 1'b0; win[m] = 1'b0; exp_out[m] = 3'b000; slot[m] = 0;
    end
  endtask

  task automatic drive_slots();
    cur_ch6 = 3'(slot[0] % 6); cur_op6 = 2'(slot[0] / 6);
    cur_ch3 = 3'(slot[1] % 3); cur_op3 = 2'(slot[1] / 3);
  endtask

  // One advance of slot-level behaviour: stored key per slot, CSM window, edges.
  task automatic model_step(input int m);
    int n, s, ch, op, lo, idx, bp;
    bit valid, drop, frc, eff, l;
    n  = (m == 0) ? 6 : 3;
    s  = slot[m];
    ch = s % n;
    op = s / n;
    lo = int'(bus.keyon_ch[1:0]);
    idx = bus.keyon_ch[2] ? lo + 3 : lo;
    valid = (lo != 3) && (idx < n);
    bp = (op == 0) ? 0 : (op == 1) ? 2 : (op == 2) ? 1 : 3;
    drop = stored[m][s];
    if (bus.up_keyon && valid && idx == ch) stored[m][s] = bus.keyon_op[bp];
    if (!csm) pend[m] = 1'b0;
    else if (ovf) pend[m] = 1'b1;
    if (pend[m] && ch == 2 && op == 0) begin
      win[m] = 1'b1; pend[m] = 1'b0;
    end
    frc = win[m] && ch == 2;
    if (ch == 2 && op == 3) win[m] = 1'b0;
    eff = drop | frc;
    l = last[m][s];
    exp_out[m] = {eff, eff & !l, !eff & l};
    last[m][s] = eff;
    slot[m] = (s + 1) % (4 * n);
  endtask

  task automatic step();
    @(posedge clk);
    if (clk_en) begin
      model_step(0);
      model_step(1);
    end
    #1;
    drive_slots();
  endtask

  task automatic idle_inputs();
    bus.up_keyon = 1'b0; bus.keyon_ch = 3'd0; bus.keyon_op = 4'd0;
    csm = 1'b0; ovf = 1'b0; clk_en = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    idle_inputs();
    drive_slots();
    if ({ii6, on6, off6, ii3, on3, off3} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 000000", {ii6, on6, off6, ii3, on3, off3});
    end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.up_keyon = 1'($urandom); bus.keyon_ch = 3'($urandom); bus.keyon_op = 4'($urandom);
      csm = 1'($urandom); ovf = 1'($urandom); clk_en = 1'($urandom);
      cur_ch6 = 3'($urandom); cur_op6 = 2'($urandom);
      cur_ch3 = 3'($urandom); cur_op3 = 2'($urandom);
      #1;
      if ({ii6, on6, off6, ii3, on3, off3} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold got %b want 000000", {ii6, on6, off6, ii3, on3, off3});
      end
      checks++;
    end
    apply_reset();
    for (int i = 0; i < 48; i++) begin
      step();
      if ({ii6, on6, off6, ii3, on3, off3} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b want 000000", i, {ii6, on6, off6, ii3, on3, off3});
      end
      checks++;
    end
  endtask

  task automatic test_keyon();
    int n_on6 = 0, n_on3 = 0, n_ii6 = 0;
    bus.keyon_ch = 3'd5; bus.keyon_op = 4'b0001; bus.up_keyon = 1'b1;
    for (int i = 0; i < 96; i++) begin
      if (i == 24) bus.up_keyon = 1'b0;
      step();
      if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
        errors++;
        $display("FAIL keyon cyc %0d got %b/%b want %b/%b", i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
      end
      checks++;
      n_on6 += int'(on6); n_on3 += int'(on3);
      if (i >= 72) n_ii6 += int'(ii6);
    end
    if (n_on6 != 1) begin errors++; $display("FAIL keyon_pulses6 got %0d want 1", n_on6); end
    checks++;
    if (n_on3 != 0) begin errors++; $display("FAIL keyon_pulses3 got %0d want 0", n_on3); end
    checks++;
    if (n_ii6 != 1) begin errors++; $display("FAIL keyon_held6 got %0d want 1", n_ii6); end
    checks++;
  endtask

  task automatic test_keyoff();
    int n_off6 = 0, n_ii6 = 0;
    bus.keyon_ch = 3'd5; bus.keyon_op = 4'b0000; bus.up_keyon = 1'b1;
    for (int i = 0; i < 72; i++) begin
      if (i == 24) bus.up_keyon = 1'b0;
      step();
      if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
        errors++;
        $display("FAIL keyoff cyc %0d got %b/%b want %b/%b", i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
      end
      checks++;
      n_off6 += int'(off6);
      if (i >= 48) n_ii6 += int'(ii6);
    end
    if (n_off6 != 1) begin errors++; $display("FAIL keyoff_pulses6 got %0d want 1", n_off6); end
    checks++;
    if (n_ii6 != 0) begin errors++; $display("FAIL keyoff_held6 got %0d want 0", n_ii6); end
    checks++;
  endtask

  task automatic test_invalid();
    logic [2:0] codes [3];
    int n_on [3];
    codes[0] = 3'd3; codes[1] = 3'd7; codes[2] = 3'd4;
    for (int c = 0; c < 3; c++) begin
      n_on[c] = 0;
      bus.keyon_ch = codes[c]; bus.keyon_op = 4'b1111; bus.up_keyon = 1'b1;
      for (int i = 0; i < 48; i++) begin
        if (i == 24) bus.up_keyon = 1'b0;
        step();
        if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
          errors++;
          $display("FAIL invalid code %0d cyc %0d got %b/%b want %b/%b", codes[c], i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
        end
        checks++;
        n_on[c] += int'(on3);
        if (c < 2) n_on[c] += int'(on6) + int'(ii6) + int'(ii3);
      end
      if (n_on[c] != 0) begin errors++; $display("FAIL invalid_quiet code %0d got %0d want 0", codes[c], n_on[c]); end
      checks++;
    end
    // Code 4 is a real channel on the 6-channel build: clear it again.
    bus.keyon_ch = 3'd4; bus.keyon_op = 4'b0000; bus.up_keyon = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 24) bus.up_keyon = 1'b0;
      step();
      if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
        errors++;
        $display("FAIL invalid_clear cyc %0d got %b/%b want %b/%b", i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
      end
      checks++;
    end
  endtask

  task automatic test_csm();
    int n_on6 = 0, n_off6 = 0, n_on3 = 0, n_off3 = 0, bad = 0;
    int p6, p3;
    csm = 1'b1;
    repeat ($urandom_range(0, 23)) step();
    ovf = 1'b1;
    step();
    ovf = 1'b0;
    for (int i = 0; i < 72; i++) begin
      step();
      if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
        errors++;
        $display("FAIL csm cyc %0d got %b/%b want %b/%b", i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
      end
      checks++;
      p6 = (slot[0] + 23) % 24;
      p3 = (slot[1] + 11) % 12;
      n_on6 += int'(on6); n_off6 += int'(off6);
      n_on3 += int'(on3); n_off3 += int'(off3);
      if ((on6 || off6 || ii6) && (p6 % 6) != 2) bad++;
      if ((on3 || off3 || ii3) && (p3 % 3) != 2) bad++;
    end
    csm = 1'b0;
    if (n_on6 != 4 || n_off6 != 4) begin
      errors++; $display("FAIL csm_edges6 got on %0d off %0d want 4 4", n_on6, n_off6);
    end
    checks++;
    if (n_on3 != 4 || n_off3 != 4) begin
      errors++; $display("FAIL csm_edges3 got on %0d off %0d want 4 4", n_on3, n_off3);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL csm_other_ch got %0d want 0", bad); end
    checks++;
  endtask

  task automatic test_clk_en_gating();
    int n_on6 = 0, n_ii6 = 0;
    apply_reset();
    bus.keyon_ch = 3'd5; bus.keyon_op = 4'b0001; bus.up_keyon = 1'b1;
    for (int i = 0; i < 192; i++) begin
      clk_en = (i % 2 == 0);
      if (i == 48) bus.up_keyon = 1'b0;
      step();
      if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
        errors++;
        $display("FAIL gating cyc %0d got %b/%b want %b/%b", i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
      end
      checks++;
      n_on6 += int'(on6);
      if (i >= 144) n_ii6 += int'(ii6);
    end
    clk_en = 1'b1;
    if (n_on6 != 2) begin errors++; $display("FAIL gating_pulse_len got %0d want 2", n_on6); end
    checks++;
    if (n_ii6 != 2) begin errors++; $display("FAIL gating_held got %0d want 2", n_ii6); end
    checks++;
  endtask

  task automatic test_random();
    int n_active = 0;
    for (int i = 0; i < 2000; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      bus.up_keyon = ($urandom_range(0, 3) == 0);
      bus.keyon_ch = 3'($urandom); bus.keyon_op = 4'($urandom);
      csm = ($urandom_range(0, 7) != 0);
      ovf = ($urandom_range(0, 39) == 0);
      step();
      if ({ii6, on6, off6} !== exp_out[0] || {ii3, on3, off3} !== exp_out[1]) begin
        errors++;
        $display("FAIL random cyc %0d got %b/%b want %b/%b", i, {ii6, on6, off6}, {ii3, on3, off3}, exp_out[0], exp_out[1]);
      end
      checks++;
      n_active += int'(ii6);
    end
    if (n_active == 0) begin errors++; $display("FAIL random_activity got 0 want >0"); end
    checks++;
    // Mid-operation reset must drop all key state.
    apply_reset();
    for (int i = 0; i < 48; i++) begin
      step();
      if ({ii6, on6, off6, ii3, on3, off3} !== 6'b0) begin
        errors++;
        $display("FAIL midreset cyc %0d got %b want 000000", i, {ii6, on6, off6, ii3, on3, off3});
      end
      checks++;
    end
  endtask

  initial begin
    model_clear();
    idle_inputs();
    drive_slots();
    rst_n = 1'b0;
    test_reset();
    test_keyon();
    test_keyoff();
    test_invalid();
    test_csm();
    test_clk_en_gating();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
